// File: rtl/branch_resolve_cycle.sv
// Execute-stage branch/jump resolution: holds the ID/EX control-flow slot and drives the fetch redirect and pipeline flushes.
// Optional statistics counters are compiled in when BRANCH_STATS_EN is defined.
module branch_resolve_cycle #(
  parameter int XLEN    = 32,
  parameter int STATS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallE,
  input  logic               ValidD,
  input  logic               BranchD,
  input  logic               JumpD,
  input  logic               JalrD,
  input  logic [2:0]         Funct3D,
  input  logic [XLEN-1:0]    RD1D,
  input  logic [XLEN-1:0]    RD2D,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    ImmExtD,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               FlushD,
  output logic               FlushE,
  output logic               MisalignE,
  output logic [STATS_W-1:0] BrCountE,
  output logic [STATS_W-1:0] TkCountE
);

  logic            valid_r, done_r, branch_r, jump_r, jalr_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] rd1_r, rd2_r, pc_r, imm_r;
  logic            cond_s, taken_s, pcsrc_s;
  logic [XLEN-1:0] target_s;

  function automatic logic branch_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic r;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = ($signed(a) < $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a < b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Condition, taken decision and target computed from the E slot
  always_comb begin
    cond_s   = branch_cond(funct3_r, rd1_r, rd2_r);
    taken_s  = jump_r | jalr_r | (branch_r & cond_s);
    target_s = {XLEN{1'b0}};
    if (!valid_r) begin
      target_s = {XLEN{1'b0}};
    end else if (jalr_r) begin
      target_s = (rd1_r + imm_r) & {{(XLEN-1){1'b1}}, 1'b0};
    end else begin
      target_s = pc_r + imm_r;
    end
    // DoneE keeps a stalled instruction from redirecting a second time
    pcsrc_s = valid_r & taken_s & ~done_r;
  end

  assign PCSrcE    = pcsrc_s;
  assign PCTargetE = target_s;
  assign FlushD    = pcsrc_s;
  assign FlushE    = pcsrc_s;
  assign MisalignE = pcsrc_s & (target_s[1:0] != 2'b00);

  // ID/EX slot: redirect beats stall beats normal load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      done_r   <= 1'b0;
      branch_r <= 1'b0;
      jump_r   <= 1'b0;
      jalr_r   <= 1'b0;
      funct3_r <= 3'b000;
      rd1_r    <= {XLEN{1'b0}};
      rd2_r    <= {XLEN{1'b0}};
      pc_r     <= {XLEN{1'b0}};
      imm_r    <= {XLEN{1'b0}};
    end else if (pcsrc_s) begin
      if (StallE) begin
        done_r <= 1'b1;
      end else begin
        valid_r  <= 1'b0;
        done_r   <= 1'b0;
        branch_r <= 1'b0;
        jump_r   <= 1'b0;
        jalr_r   <= 1'b0;
      end
    end else if (StallE) begin
      done_r <= done_r;
    end else begin
      valid_r  <= ValidD;
      done_r   <= 1'b0;
      branch_r <= BranchD;
      jump_r   <= JumpD;
      jalr_r   <= JalrD;
      funct3_r <= Funct3D;
      rd1_r    <= RD1D;
      rd2_r    <= RD2D;
      pc_r     <= PCD;
      imm_r    <= ImmExtD;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STATS_W-1:0] br_count_r, tk_count_r;

  // Committed control-flow and redirect counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_r <= {STATS_W{1'b0}};
      tk_count_r <= {STATS_W{1'b0}};
    end else begin
      if (valid_r && !StallE && (branch_r || jump_r || jalr_r)) begin
        br_count_r <= br_count_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end
      if (pcsrc_s) begin
        tk_count_r <= tk_count_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign BrCountE = br_count_r;
  assign TkCountE = tk_count_r;
`else
  assign BrCountE = {STATS_W{1'b0}};
  assign TkCountE = {STATS_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_cycle.sv
// Scoreboard bench for branch_resolve_cycle: directed vectors push per-cycle expectations, a negedge monitor checks them.
module tb_branch_resolve_cycle;

  logic        clk, rst, StallE, ValidD, BranchD, JumpD, JalrD;
  logic [2:0]  Funct3D;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD;
  logic        PCSrcE, FlushD, FlushE, MisalignE;
  logic [31:0] PCTargetE, BrCountE, TkCountE;

  branch_resolve_cycle #(.XLEN(32), .STATS_W(32)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .ValidD(ValidD), .BranchD(BranchD),
    .JumpD(JumpD), .JalrD(JalrD), .Funct3D(Funct3D), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .ImmExtD(ImmExtD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .FlushD(FlushD), .FlushE(FlushE), .MisalignE(MisalignE),
    .BrCountE(BrCountE), .TkCountE(TkCountE)
  );

  typedef struct {
    int          cyc;
    logic        src;
    logic [31:0] tgt;
    logic        mis;
    logic        cnt0;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic expect_at(input int c, input logic src, input logic [31:0] tgt,
                           input logic mis, input logic cnt0, input string name);
    exp_t e;
    e.cyc = c; e.src = src; e.tgt = tgt; e.mis = mis; e.cnt0 = cnt0; e.name = name;
    q.push_back(e);
  endtask

  task automatic issue(input logic v, input logic b, input logic j, input logic jr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] bb,
                       input logic [31:0] pc, input logic [31:0] imm);
    ValidD = v; BranchD = b; JumpD = j; JalrD = jr; Funct3D = f3;
    RD1D = a; RD2D = bb; PCD = pc; ImmExtD = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop and check the expectation due in the current cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    logic ok;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      tests++; failed++;
      $display("FAIL %s: sample missed, due cycle %0d now %0d", e.name, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      tests++;
      ok = (PCSrcE === e.src) && (FlushD === e.src) && (FlushE === e.src) &&
           (PCTargetE === e.tgt) && (MisalignE === e.mis);
`ifdef BRANCH_STATS_EN
      if (e.cnt0) ok = ok && (BrCountE === 32'd0) && (TkCountE === 32'd0);
`else
      ok = ok && (BrCountE === 32'd0) && (TkCountE === 32'd0);
`endif
      if (!ok) begin
        failed++;
        $display("FAIL %s: got src=%b fd=%b fe=%b tgt=%h mis=%b br=%0d tk=%0d, want src=%b tgt=%h mis=%b",
                 e.name, PCSrcE, FlushD, FlushE, PCTargetE, MisalignE, BrCountE, TkCountE,
                 e.src, e.tgt, e.mis);
      end
    end
  end

  initial begin
    rst = 1'b1; StallE = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick(); tick();
    expect_at(cyc, 1'b0, 32'h0, 1'b0, 1'b1, "reset_state");
    tick();
    rst = 1'b0;
    tick();

    // BEQ taken, then the wrong-path instruction is squashed into a bubble
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    expect_at(cyc + 1, 1'b1, 32'h120, 1'b0, 1'b0, "beq_taken"); tick();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h500, 32'h4);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, "beq_bubble"); tick();

    // BLT signed taken, BLTU same operands not taken
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40);
    expect_at(cyc + 1, 1'b1, 32'h240, 1'b0, 1'b0, "blt_taken"); tick();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, "blt_bubble"); tick();
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h10);
    expect_at(cyc + 1, 1'b0, 32'h310, 1'b0, 1'b0, "bltu_not_taken"); tick();

    // BGEU with wrapped-small rs1 not taken; reserved funct3 never taken
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'd1, 32'hFFFFFFFF, 32'h340, 32'h8);
    expect_at(cyc + 1, 1'b0, 32'h348, 1'b0, 1'b0, "bgeu_not_taken"); tick();
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'd7, 32'd7, 32'h20, 32'h8);
    expect_at(cyc + 1, 1'b0, 32'h28, 1'b0, 1'b0, "f3_010_never"); tick();

    // JALR clears bit 0 and flags a misaligned target
    issue(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h203, 32'd0, 32'h400, 32'd0);
    expect_at(cyc + 1, 1'b1, 32'h202, 1'b1, 1'b0, "jalr_misalign"); tick();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, "jalr_bubble"); tick();

    // Branch and JALR both set: JALR target wins
    issue(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h1000, 32'h1000, 32'h700, 32'h10);
    expect_at(cyc + 1, 1'b1, 32'h1010, 1'b0, 1'b0, "multi_jalr_wins"); tick();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h10, 32'h8);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, "multi_bubble"); tick();
    expect_at(cyc + 1, 1'b0, 32'h18, 1'b0, 1'b0, "plain_alu_no_redirect"); tick();

    // Taken BNE held by a 3-cycle stall: one-shot redirect, then next D loads
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'd2, 32'h600, 32'h100);
    expect_at(cyc + 1, 1'b1, 32'h700, 1'b0, 1'b0, "bne_taken"); tick();
    StallE = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h900, 32'h4);
    expect_at(cyc + 1, 1'b0, 32'h700, 1'b0, 1'b0, "stall_hold_1"); tick();
    expect_at(cyc + 1, 1'b0, 32'h700, 1'b0, 1'b0, "stall_hold_2"); tick();
    expect_at(cyc + 1, 1'b0, 32'h700, 1'b0, 1'b0, "stall_hold_3"); tick();
    StallE = 1'b0;
    expect_at(cyc + 1, 1'b1, 32'h904, 1'b0, 1'b0, "after_stall_jal"); tick();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, "after_stall_bubble"); tick();

    // JAL target wraps modulo 2^32
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h20);
    expect_at(cyc + 1, 1'b1, 32'h10, 1'b0, 1'b0, "jal_wrap"); tick();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b0, "jal_wrap_bubble"); tick();

    // BGE signed taken (5 >= -3)
    issue(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'd5, 32'hFFFFFFFD, 32'h1000, 32'hC);
    expect_at(cyc + 1, 1'b1, 32'h100C, 1'b0, 1'b0, "bge_taken"); tick();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // Async reset in the middle of a redirect cycle
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h2000, 32'h40);
    tick();
    #1 rst = 1'b1;
    expect_at(cyc, 1'b0, 32'h0, 1'b0, 1'b1, "rst_mid_redirect");
    tick();
    rst = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    expect_at(cyc + 1, 1'b0, 32'h0, 1'b0, 1'b1, "post_rst_idle"); tick();

    tick(); tick();
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
